// File: rtl/mpeg_bitreader_pkg.sv
// Shared types and constants for the MPEG input stream bit reader.
package mpeg_bitreader_pkg;

    localparam int PTR_W      = 14;
    localparam int WORD_BYTES = 4;
    localparam int BUF_W      = 64;
    localparam int CNT_W      = 7;
    localparam logic [23:0] START_CODE_PREFIX = 24'h000001;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LOAD
    } fetch_state_t;

    // RAM words hold the first stream byte in [7:0]; the buffer wants it in the MSBs.
    function automatic logic [31:0] byte_reverse(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mpeg_bitreader_fetch.sv
// Word fetch sequencer: IDLE -> READ -> LOAD, one 32-bit word per three cycles at most.
module mpeg_bitreader_fetch
    import mpeg_bitreader_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [PTR_W-1:0]  wr_byte_ptr,
    input  logic              room,
    output logic [ADDR_W-1:0] raddr,
    output logic              load,
    output logic [PTR_W-1:0]  fetch_ptr_next
);

    fetch_state_t     state, state_next;
    logic [PTR_W-1:0] fetch_ptr;
    logic [PTR_W-1:0] fill;
    logic             word_ready;
    logic             start;

    // Modulo distance works across the wrap bit, so only whole words are ever fetched.
    assign fill       = wr_byte_ptr - fetch_ptr;
    assign word_ready = (fill >= PTR_W'(WORD_BYTES));
    assign load       = (state == LOAD) && !flush;

    always_comb begin
        state_next     = state;
        start          = 1'b0;
        fetch_ptr_next = fetch_ptr;
        if (flush) begin
            state_next     = IDLE;
            fetch_ptr_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (room && word_ready) begin
                        state_next = READ;
                        start      = 1'b1;
                    end
                end
                READ: state_next = LOAD;
                LOAD: begin
                    state_next     = IDLE;
                    fetch_ptr_next = fetch_ptr + PTR_W'(WORD_BYTES);
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            fetch_ptr <= '0;
            raddr     <= '0;
        end else begin
            state     <= state_next;
            fetch_ptr <= fetch_ptr_next;
            if (start) begin
                raddr <= fetch_ptr[ADDR_W+1:2];
            end
        end
    end

endmodule

// File: rtl/mpeg_input_stream_bitreader.sv
// MPEG input stream bit reader: 64-bit MSB-first buffer behind a 32-bit peek window.
// Define MPEG_BITREADER_STARTCODE_EN to build the hardware start-code scan.
module mpeg_input_stream_bitreader
    import mpeg_bitreader_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int BUF_W  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] raddr,
    input  logic [31:0]       q,
    input  logic [PTR_W-1:0]  wr_byte_ptr,
    output logic [PTR_W-1:0]  rd_byte_ptr,
    input  logic              flush,
    output logic [31:0]       window,
    output logic [CNT_W-1:0]  bits_avail,
    input  logic              consume,
    input  logic [5:0]        consume_len,
    input  logic              byte_align,
    output logic              underrun,
    input  logic              seek_startcode,
    output logic              startcode_found
);

    logic [BUF_W-1:0] buffer, shifted, appended, buffer_next;
    logic [CNT_W-1:0] shift_amt, user_shift, avail_after, avail_next;
    logic [PTR_W-1:0] fetch_ptr_next, rd_next;
    logic             underrun_set, user_underrun, load, room;

    assign window = buffer[BUF_W-1 -: 32];

    // Parser requests: byte_align wins over consume and silently drops it.
    always_comb begin
        user_shift    = '0;
        user_underrun = 1'b0;
        if (byte_align) begin
            user_shift = {4'd0, bits_avail[2:0]};
        end else if (consume) begin
            if (consume_len == 6'd0 || {1'b0, consume_len} > bits_avail) begin
                user_underrun = 1'b1;
            end else begin
                user_shift = {1'b0, consume_len};
            end
        end
    end

`ifdef MPEG_BITREADER_STARTCODE_EN
    logic scanning, scan_next, found_next, prefix_seen;

    assign prefix_seen = (bits_avail >= 7'd24) && (window[31:8] == START_CODE_PREFIX);

    always_comb begin
        shift_amt    = '0;
        underrun_set = 1'b0;
        scan_next    = scanning;
        found_next   = 1'b0;
        if (scanning) begin
            if (prefix_seen) begin
                scan_next  = 1'b0;
                found_next = 1'b1;
            end else if (bits_avail >= 7'd32) begin
                shift_amt = 7'd8;
            end
        end else if (seek_startcode) begin
            shift_amt = {4'd0, bits_avail[2:0]};
            scan_next = 1'b1;
        end else begin
            shift_amt    = user_shift;
            underrun_set = user_underrun;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scanning        <= 1'b0;
            startcode_found <= 1'b0;
        end else if (flush) begin
            scanning        <= 1'b0;
            startcode_found <= 1'b0;
        end else begin
            scanning        <= scan_next;
            startcode_found <= found_next;
        end
    end
`else
    logic seek_unused;

    assign seek_unused     = seek_startcode;
    assign shift_amt       = user_shift;
    assign underrun_set    = user_underrun;
    assign startcode_found = 1'b0;
`endif

    // Shift first, then a loaded word lands directly below the surviving bits.
    always_comb begin
        shifted     = buffer << shift_amt;
        avail_after = bits_avail - shift_amt;
        appended    = {byte_reverse(q), {(BUF_W-32){1'b0}}} >> avail_after;
        buffer_next = load ? (shifted | appended) : shifted;
        avail_next  = load ? (avail_after + 7'd32) : avail_after;
        rd_next     = fetch_ptr_next - PTR_W'((avail_next + 7'd7) >> 3);
    end

    assign room = (avail_after <= 7'd32);

    mpeg_bitreader_fetch #(
        .ADDR_W(ADDR_W)
    ) u_fetch (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .wr_byte_ptr   (wr_byte_ptr),
        .room          (room),
        .raddr         (raddr),
        .load          (load),
        .fetch_ptr_next(fetch_ptr_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buffer      <= '0;
            bits_avail  <= '0;
            rd_byte_ptr <= '0;
            underrun    <= 1'b0;
        end else if (flush) begin
            buffer      <= '0;
            bits_avail  <= '0;
            rd_byte_ptr <= '0;
            underrun    <= 1'b0;
        end else begin
            buffer      <= buffer_next;
            bits_avail  <= avail_next;
            rd_byte_ptr <= rd_next;
            if (underrun_set) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mpeg_input_stream_bitreader.sv
// Bench for mpeg_input_stream_bitreader: bit-queue reference model, directed and random stimulus.
`timescale 1ns/1ps
module tb_mpeg_input_stream_bitreader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] raddr;
    logic [31:0] q = '0;
    logic [13:0] wr_byte_ptr;
    logic [13:0] rd_byte_ptr;
    logic        flush, consume, byte_align, seek_startcode;
    logic [5:0]  consume_len;
    logic [31:0] window;
    logic [6:0]  bits_avail;
    logic        underrun, startcode_found;

    always #5 clk = ~clk;

    mpeg_input_stream_bitreader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .raddr          (raddr),
        .q              (q),
        .wr_byte_ptr    (wr_byte_ptr),
        .rd_byte_ptr    (rd_byte_ptr),
        .flush          (flush),
        .window         (window),
        .bits_avail     (bits_avail),
        .consume        (consume),
        .consume_len    (consume_len),
        .byte_align     (byte_align),
        .underrun       (underrun),
        .seek_startcode (seek_startcode),
        .startcode_found(startcode_found)
    );

    // FIFO RAM: byte writes from the bench, registered 32-bit reads.
    logic [7:0] mem [0:8191];
    always @(posedge clk)
        q <= {mem[{raddr, 2'd3}], mem[{raddr, 2'd2}], mem[{raddr, 2'd1}], mem[{raddr, 2'd0}]};

    // Reference model: the buffer is a queue of stream bits, head = next bit.
    bit mq[$];
    int m_fp, m_phase, m_raddr;
    bit m_und, m_scan, m_found;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_window();
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++)
            if (i < mq.size()) w[31-i] = mq[i];
        return w;
    endfunction

    function automatic int m_rd();
        return (m_fp - (mq.size() + 7) / 8) & 16383;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fp = 0; m_phase = 0; m_raddr = 0;
        m_und = 0; m_scan = 0; m_found = 0;
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) mq.push_back(v[b]);
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int avail, drop;
        m_found = 0;
        if (flush) begin
            model_reset();
            return;
        end
        avail = mq.size();
        drop = 0;
`ifdef MPEG_BITREADER_STARTCODE_EN
        if (m_scan) begin
            if (avail >= 24 && m_window()[31:8] == 24'h000001) begin
                m_found = 1; m_scan = 0;
            end else if (avail >= 32) drop = 8;
        end else if (seek_startcode) begin
            drop = avail % 8; m_scan = 1;
        end else
`endif
        if (byte_align) drop = avail % 8;
        else if (consume) begin
            if (consume_len == 0 || int'(consume_len) > avail) m_und = 1;
            else drop = int'(consume_len);
        end
        repeat (drop) void'(mq.pop_front());
        if (m_phase == 2) begin
            for (int k = 0; k < 4; k++) push_byte(mem[(m_fp + k) % 8192]);
            m_fp = (m_fp + 4) % 16384;
            m_phase = 0;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (mq.size() <= 32 && ((int'(wr_byte_ptr) - m_fp) & 16383) >= 4) begin
            m_phase = 1;
            m_raddr = (m_fp / 4) % 2048;
        end
    endtask

    task automatic check_all();
        chk("window", window, m_window());
        chk("bits_avail", bits_avail, mq.size());
        chk("rd_byte_ptr", rd_byte_ptr, m_rd());
        chk("underrun", underrun, m_und);
        chk("startcode_found", startcode_found, m_found);
        if (m_phase == 1) chk("raddr", raddr, m_raddr);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic write_byte(input logic [7:0] v);
        mem[wr_byte_ptr[12:0]] = v;
        wr_byte_ptr = wr_byte_ptr + 14'd1;
    endtask

    task automatic do_flush();
        flush = 1'b1; wr_byte_ptr = '0;
        step();
        flush = 1'b0;
    endtask

    task automatic do_consume(input int len);
        consume = 1'b1; consume_len = 6'(len);
        step();
        consume = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, pulses;
        bit seen_top, wrapped;
        logic [10:0] prev_raddr;
        logic [31:0] exp_word;

        flush = 0; consume = 0; consume_len = '0; byte_align = 0; seek_startcode = 0;
        wr_byte_ptr = '0;
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_window", window, 0);
        chk("reset_bits_avail", bits_avail, 0);
        chk("reset_rd_byte_ptr", rd_byte_ptr, 0);
        chk("reset_raddr", raddr, 0);
        chk("reset_underrun", underrun, 0);
        chk("reset_startcode_found", startcode_found, 0);
        reset_n = 1'b1;

        // Two words with a sequence-header start code.
        foreach (mem[i]) if (i < 0) mem[i] = '0;
        write_byte(8'h00); write_byte(8'h00); write_byte(8'h01); write_byte(8'hB3);
        write_byte(8'h12); write_byte(8'h34); write_byte(8'h56); write_byte(8'h78);
        repeat (7) step();
        chk("t1_bits_avail", bits_avail, 64);
        chk("t1_window", window, 32'h000001B3);

        do_consume(4);
        chk("t2_window_c4", window, 32'h00001B31);
        do_consume(28);
        chk("t2_window_c28", window, 32'h12345678);
        chk("t2_bits_avail", bits_avail, 32);
        chk("t2_rd_byte_ptr", rd_byte_ptr, 4);

        // Partial trailing word is never fetched.
        do_flush();
        write_byte(8'hAA); write_byte(8'hBB); write_byte(8'hCC);
        repeat (5) step();
        chk("t3_bits_avail", bits_avail, 0);
        do_consume(1);
        chk("t3_underrun", underrun, 1);

        // Whole RAM as a ramp, drained at 32 bits per cycle.
        do_flush();
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 7 + 3);
        wr_byte_ptr = 14'd8192;
        consume = 1'b1; consume_len = 6'd32;
        k = 0; seen_top = 0; wrapped = 0; prev_raddr = raddr;
        for (int cyc = 0; cyc < 7000 && k < 2048; cyc++) begin
            if (mq.size() >= 32) begin
                exp_word = {8'(4*k*7 + 3), 8'((4*k+1)*7 + 3), 8'((4*k+2)*7 + 3), 8'((4*k+3)*7 + 3)};
                chk("t4_ramp_word", window, exp_word);
                k++;
            end
            step();
            if (raddr == 11'd2047) seen_top = 1;
            if (prev_raddr == 11'd2047 && raddr == 11'd0) wrapped = 1;
            prev_raddr = raddr;
        end
        consume = 1'b0;
        chk("t4_words_delivered", k, 2048);
        chk("t4_rd_byte_ptr", rd_byte_ptr, 8192);
        chk("t4_raddr_reached_2047", seen_top, 1);
        wr_byte_ptr = 14'd8200;
        for (int i = 0; i < 8; i++) begin
            step();
            if (prev_raddr == 11'd2047 && raddr == 11'd0) wrapped = 1;
            prev_raddr = raddr;
        end
        chk("t4_raddr_wrap", wrapped, 1);
        chk("t4_bits_after_wrap", bits_avail, 64);

        // byte_align, and its priority over consume.
        do_flush();
        for (int i = 0; i < 8; i++) write_byte(8'($urandom));
        repeat (7) step();
        do_consume(3);
        chk("t5_bits_c3", bits_avail, 61);
        byte_align = 1'b1; step(); byte_align = 1'b0;
        chk("t5_bits_align", bits_avail, 56);
        do_consume(5);
        byte_align = 1'b1; consume = 1'b1; consume_len = 6'd4;
        step();
        byte_align = 1'b0; consume = 1'b0;
        chk("t5_align_wins", bits_avail, 48);
        chk("t5_no_underrun", underrun, 0);

        // Start-code scan.
        do_flush();
        write_byte(8'hFF); write_byte(8'h00); write_byte(8'h00); write_byte(8'h01);
        write_byte(8'hB8); write_byte(8'hAA); write_byte(8'hBB); write_byte(8'hCC);
        repeat (7) step();
        seek_startcode = 1'b1; step(); seek_startcode = 1'b0;
`ifdef MPEG_BITREADER_STARTCODE_EN
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (startcode_found) pulses++;
        end
        chk("t6_found_pulses", pulses, 1);
        chk("t6_window_prefix", window[31:8], 24'h000001);
        chk("t6_bits_avail", bits_avail, 56);
`else
        pulses = 0;
        chk("t6_seek_ignored_bits", bits_avail, 64);
        chk("t6_found_tied_low", startcode_found, 0);
`endif

        // Randomized traffic.
        do_flush();
        for (int n = 0; n < 3000; n++) begin
            flush          = ($urandom_range(0, 99) == 0);
            byte_align     = ($urandom_range(0, 15) == 0);
            seek_startcode = ($urandom_range(0, 63) == 0);
            consume        = 1'($urandom_range(0, 1));
            consume_len    = ($urandom_range(0, 40) == 0) ? 6'd0 : 6'($urandom_range(1, 34));
            if (flush) wr_byte_ptr = '0;
            else
                repeat ($urandom_range(0, 3))
                    if (((int'(wr_byte_ptr) - m_rd()) & 16383) < 8000) write_byte(8'($urandom));
            step();
        end
        flush = 0; byte_align = 0; seek_startcode = 0; consume = 0;

        // Asynchronous reset while a word is in flight.
        do_flush();
        for (int i = 0; i < 8; i++) write_byte(8'($urandom));
        repeat (5) step();
        chk("t7_load_pending", m_phase, 2);
        reset_n = 1'b0;
        #1;
        chk("t7_async_window", window, 0);
        chk("t7_async_bits", bits_avail, 0);
        chk("t7_async_raddr", raddr, 0);
        chk("t7_async_rd", rd_byte_ptr, 0);
        model_reset();
        wr_byte_ptr = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) step();
        chk("t7_word_abandoned", bits_avail, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
